// File: rtl/hazard_stall_unit_pkg.sv
// Shared register-file constants, tag payload type and small helpers for the hazard unit.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned TAG_W = 6;

    localparam logic [1:0]       JAL_CODE = 2'b10;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // One in-flight destination entry: valid bit plus destination register.
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] r;
    } tag_t;

    // Same destination remap the WB mux applies: jal links into $31.
    function automatic logic [REG_W-1:0] rd_remap(input logic [1:0] jal, input logic [REG_W-1:0] rd);
        return (jal == JAL_CODE) ? REG_RA : rd;
    endfunction

    // $0 is never a pending write.
    function automatic logic tag_live(input tag_t t);
        return t.v && (t.r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage request/stall bundle between the pipeline control and the hazard unit.
interface hazard_stall_unit_if
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_we;
    logic [REG_W-1:0] id_rd;
    logic [1:0]       id_jal;
    logic             ex_flush;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd, id_jal, ex_flush,
        input  stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd, id_jal, ex_flush,
        output stall, stall_cnt
    );
endinterface

// File: rtl/hazard_tag_pipe.sv
// In-flight destination tag shift register (tag[0]=EX .. tag[DEPTH-1]=WB) with EX flush and source compare.
module hazard_tag_pipe
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  tag_t             push_i,
    input  logic             flush_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    output logic             hit_rs_c,
    output logic             hit_rt_c,
    output logic [DEPTH-1:0] tag_v_o
);

    // With a write-first regfile the WB entry is already visible to ID reads.
    localparam int unsigned NCMP = WB_BYPASS ? DEPTH - 1 : DEPTH;

    tag_t tag_q [DEPTH];
    tag_t tag_d [DEPTH];

    // Next-state: shift down the pipe; a flush also kills the instruction leaving EX.
    always_comb begin
        tag_d[0] = push_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (flush_i) begin
            tag_d[1] = '0;
        end
    end

    // Tag storage, cleared asynchronously so a reset drops any pending stall at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Source compare against the live entries of the compare set.
    always_comb begin
        hit_rs_c = 1'b0;
        hit_rt_c = 1'b0;
        for (int i = 0; i < int'(NCMP); i++) begin
            if (tag_live(tag_q[i]) && (tag_q[i].r == rs_i)) hit_rs_c = 1'b1;
            if (tag_live(tag_q[i]) && (tag_q[i].r == rt_i)) hit_rt_c = 1'b1;
        end
    end

    // Valid bits exposed for observation.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            tag_v_o[i] = tag_q[i].v;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Read-after-write stall generator for the non-forwarding pipeline, with jal-aware destination tracking.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_unit_if.slave  bus
);

    logic [REG_W-1:0] rd_eff;
    logic             pipe_hit_rs;
    logic             pipe_hit_rt;
    logic             hit_rs;
    logic             hit_rt;
    logic             stall_c;
    logic             issue;
    tag_t             push;
    logic [DEPTH-1:0] tag_v;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    hazard_tag_pipe #(
        .DEPTH     (DEPTH),
        .WB_BYPASS (WB_BYPASS)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push),
        .flush_i  (bus.ex_flush),
        .rs_i     (bus.id_rs),
        .rt_i     (bus.id_rt),
        .hit_rs_c (pipe_hit_rs),
        .hit_rt_c (pipe_hit_rt),
        .tag_v_o  (tag_v)
    );

    // Stall decision and the tag pushed into EX (bubble unless the ID instruction really issues).
    always_comb begin
        rd_eff  = rd_remap(bus.id_jal, bus.id_rd);
        hit_rs  = bus.id_use_rs && (bus.id_rs != REG_ZERO) && pipe_hit_rs;
        hit_rt  = bus.id_use_rt && (bus.id_rt != REG_ZERO) && pipe_hit_rt;
        stall_c = !bus.ex_flush && bus.id_valid && (hit_rs || hit_rt);
        issue   = bus.id_valid && !stall_c && !bus.ex_flush;
        push    = '0;
        if (issue) begin
            push.v = bus.id_we && (rd_eff != REG_ZERO);
            push.r = rd_eff;
        end
    end

    // Saturating stalled-cycle counter next state.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stall statistics register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (DEPTH=3, WB_BYPASS=1, CNT_W=4).
module tb_hazard_stall_unit;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(
        .DEPTH     (3),
        .WB_BYPASS (1'b1),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic we,
                          input logic [4:0] rd, input logic [1:0] jal, input logic fl);
        bus.id_valid  = v;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_we     = we;
        bus.id_rd     = rd;
        bus.id_jal    = jal;
        bus.ex_flush  = fl;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        idle();
        tick();
        tick();
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        check("rst_tags", 32'(u_dut.tag_v), 32'd0);
        rst_n = 1'b1;
        tick();

        // addu $3,$1,$2 then addu $4,$3,$2: two stall cycles
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'b00, 1'b0);
        check("raw_writer_nostall", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 2'b00, 1'b0);
        check("raw_stall1", 32'(bus.stall), 32'd1);
        tick();
        check("raw_stall2", 32'(bus.stall), 32'd1);
        tick();
        check("raw_release", 32'(bus.stall), 32'd0);
        tick();
        check("raw_cnt", 32'(bus.stall_cnt), 32'd2);
        drain();

        // jal (rd=5 remapped to $31) then jr $31
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2'b10, 1'b0);
        check("jal_nostall", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
        check("jal_reader5_nostall", 32'(bus.stall), 32'd0);
        set_id(1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
        check("jr31_stall1", 32'(bus.stall), 32'd1);
        tick();
        check("jr31_stall2", 32'(bus.stall), 32'd1);
        tick();
        check("jr31_release", 32'(bus.stall), 32'd0);
        tick();
        check("jal_cnt", 32'(bus.stall_cnt), 32'd4);
        drain();

        // write $0 then read $0
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0);
        tick();
        check("r0_tag0_invalid", 32'(u_dut.tag_v[0]), 32'd0);
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        check("r0_nostall1", 32'(bus.stall), 32'd0);
        tick();
        check("r0_nostall2", 32'(bus.stall), 32'd0);
        drain();

        // write $7, then flush while a reader of $7 sits in ID
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 2'b00, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1);
        check("flush_overrides_stall", 32'(bus.stall), 32'd0);
        tick();
        check("flush_tags_squashed", 32'(u_dut.tag_v), 32'd0);
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
        check("flush_after_nostall1", 32'(bus.stall), 32'd0);
        tick();
        check("flush_after_nostall2", 32'(bus.stall), 32'd0);
        check("flush_cnt", 32'(bus.stall_cnt), 32'd4);
        drain();

        // reset asserted in the middle of a stall
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 2'b00, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
        check("midrst_stall", 32'(bus.stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stall_drop", 32'(bus.stall), 32'd0);
        check("midrst_cnt", 32'(bus.stall_cnt), 32'd0);
        check("midrst_tags", 32'(u_dut.tag_v), 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // counter saturation: each writer/reader pair contributes two stall cycles
        for (int k = 0; k < 11; k++) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 2'b00, 1'b0);
            tick();
            set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
            repeat (3) tick();
            if (k == 6) check("sat_cnt_14", 32'(bus.stall_cnt), 32'hE);
        end
        check("sat_cnt_hold", 32'(bus.stall_cnt), 32'hF);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
